// File: rtl/x_byte_des_arb.sv
`default_nettype none
// ============================================================================
// Module   : x_byte_des_arb
// Purpose  : Frame-level arbiter in front of x_byte_des. Shares the single
//            byte input of the deserializer between N_REQ byte-stream
//            requesters. One requester is locked for a whole BYTES-byte
//            frame; ownership rotates round-robin between frames. A stalled
//            frame is padded with 0x00 after TIMEOUT idle cycles, so the
//            downstream 64-bit word alignment is never lost.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk          in   1            clock
//   i_rst          in   1            asynchronous reset, active-low
//   i_req_valid    in   N_REQ        requester i presents i_req_byte[i*8+:8]
//   i_req_byte     in   N_REQ*8      requester byte lanes
//   o_req_ready    out  N_REQ        byte taken from requester i (valid&ready)
//   o_des_valid    out  1            byte strobe towards x_byte_des
//   o_des_cmd      out  8            byte towards x_byte_des
//   o_owner        out  clog2(N_REQ) current / last granted requester
//   o_busy         out  1            high while a frame is locked or flushing
//   o_frame_done   out  1            pulse with the last byte of a full frame
//   o_frame_abort  out  1            pulse with the last pad byte of a frame
// ============================================================================
module x_byte_des_arb #(
  parameter  int N_REQ   = 2,
  parameter  int BYTES   = 8,
  parameter  int TIMEOUT = 255,
  localparam int OWNER_W = $clog2(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [N_REQ*8-1:0]   i_req_byte,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_des_valid,
  output logic [7:0]           o_des_cmd,
  output logic [OWNER_W-1:0]   o_owner,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_frame_abort
);

  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]   C_LAST_CNT = CNT_W'(BYTES - 1);
  localparam logic [TMR_W-1:0]   C_TIMEOUT  = TMR_W'(TIMEOUT);
  localparam logic [OWNER_W-1:0] C_LAST_REQ = OWNER_W'(N_REQ - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]         state_q,      state_d;
  logic [OWNER_W-1:0] owner_q,      owner_d;
  logic [OWNER_W-1:0] last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [TMR_W-1:0]   timer_q,      timer_d;
  logic               des_valid_q,  des_valid_d;
  logic [7:0]         des_cmd_q,    des_cmd_d;
  logic               done_q,       done_d;
  logic               abort_q,      abort_d;

  logic [OWNER_W-1:0] w_pick;
  logic [OWNER_W-1:0] w_cand;
  logic               w_found;
  logic               w_xfer;
  logic [7:0]         w_owner_byte;

  // Round-robin search starting one past the last frame owner. Reset sets
  // last_owner to N_REQ-1 so requester 0 is the first one examined.
  always_comb begin
    w_pick  = last_owner_q;
    w_found = 1'b0;
    w_cand  = last_owner_q;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = (w_cand == C_LAST_REQ) ? '0 : w_cand + OWNER_W'(1);
      if (!w_found && i_req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Ready is combinational so the owner streams one byte per cycle.
  assign o_req_ready  = (state_q == ST_LOCK) ? (N_REQ'(1) << owner_q) : '0;
  assign w_xfer       = |(i_req_valid & o_req_ready);
  assign w_owner_byte = i_req_byte[{owner_q, 3'b000} +: 8];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    des_valid_d  = 1'b0;
    des_cmd_d    = 8'h00;
    done_d       = 1'b0;
    abort_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|i_req_valid) begin
          owner_d = w_pick;
          cnt_d   = '0;
          timer_d = '0;
          state_d = ST_LOCK;
        end
      end

      ST_LOCK: begin
        // A transfer always beats a timeout landing in the same cycle.
        if (w_xfer) begin
          des_valid_d = 1'b1;
          des_cmd_d   = w_owner_byte;
          timer_d     = '0;
          if (cnt_q == C_LAST_CNT) begin
            cnt_d        = '0;
            done_d       = 1'b1;
            last_owner_d = owner_q;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (TIMEOUT != 0 && timer_q == C_TIMEOUT) begin
          timer_d = '0;
          state_d = ST_FLUSH;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_FLUSH: begin
        // Fill the rest of the frame with zero bytes, one per cycle.
        des_valid_d = 1'b1;
        if (cnt_q == C_LAST_CNT) begin
          cnt_d        = '0;
          abort_d      = 1'b1;
          last_owner_d = owner_q;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= C_LAST_REQ;
      cnt_q        <= '0;
      timer_q      <= '0;
      des_valid_q  <= 1'b0;
      des_cmd_q    <= 8'h00;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      des_valid_q  <= des_valid_d;
      des_cmd_q    <= des_cmd_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

  assign o_des_valid   = des_valid_q;
  assign o_des_cmd     = des_cmd_q;
  assign o_owner       = owner_q;
  assign o_busy        = (state_q == ST_LOCK) || (state_q == ST_FLUSH);
  assign o_frame_done  = done_q;
  assign o_frame_abort = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_x_byte_des_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_byte_des_arb
// Purpose  : Self-checking bench for x_byte_des_arb. A three-requester
//            instance is driven from per-requester byte queues; each accepted
//            byte pushes its expected output onto a scoreboard that is popped
//            as bytes leave the arbiter. A second instance with the timeout
//            disabled covers the long-stall case.
// Revision : 1.0  initial release
// ============================================================================
module tb_x_byte_des_arb;

  localparam int N       = 3;
  localparam int TIMEOUT = 255;

  typedef struct packed {
    logic [7:0] cmd;
    logic [1:0] own;
    logic       done;
    logic       abort;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_byte;
  logic [N-1:0]   ready;
  logic           des_valid;
  logic [7:0]     des_cmd;
  logic [1:0]     owner;
  logic           busy, done, abort;

  logic [1:0]  v4;
  logic [15:0] b4;
  logic [1:0]  r4;
  logic        dv4;
  logic [7:0]  c4;
  logic        own4;
  logic        busy4, dn4, ab4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t       exp_q[$];
  logic [7:0] src_q[N][$];
  int         frame_log[$];
  int         wait_frames[N];
  bit         in_frame   = 1'b0;
  bit         gap_en     = 1'b0;
  bit         abort_seen = 1'b0;
  int         frame_owner, frame_cnt, leak_cnt;
  int         raise_cyc, first_des_cyc, last_des_cyc, abort_cyc, last_hs_cyc;
  logic [63:0] obs_word;
  int         n4, dn4_cnt, ab4_cnt;
  logic [63:0] w4;

  x_byte_des_arb #(.N_REQ(N), .BYTES(8), .TIMEOUT(TIMEOUT)) u_dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_req_valid   (req_valid),
    .i_req_byte    (req_byte),
    .o_req_ready   (ready),
    .o_des_valid   (des_valid),
    .o_des_cmd     (des_cmd),
    .o_owner       (owner),
    .o_busy        (busy),
    .o_frame_done  (done),
    .o_frame_abort (abort)
  );

  x_byte_des_arb #(.N_REQ(2), .BYTES(8), .TIMEOUT(0)) u_dut_nto (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_req_valid   (v4),
    .i_req_byte    (b4),
    .o_req_ready   (r4),
    .o_des_valid   (dv4),
    .o_des_cmd     (c4),
    .o_owner       (own4),
    .o_busy        (busy4),
    .o_frame_done  (dn4),
    .o_frame_abort (ab4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bench-side view of a byte taken from requester i at the last edge.
  task automatic accept(input int i);
    logic [7:0] b;
    exp_t       e;
    b = src_q[i].pop_front();
    last_hs_cyc = cyc;
    if (!in_frame) begin
      in_frame    = 1'b1;
      frame_owner = i;
      frame_cnt   = 0;
      frame_log.push_back(i);
      for (int j = 0; j < N; j++) begin
        if (j == i)                     wait_frames[j] = 0;
        else if (src_q[j].size() != 0)  wait_frames[j]++;
        else                            wait_frames[j] = 0;
        if (gap_en && j != i) chk("starve", 64'(wait_frames[j] <= N - 1), 64'd1);
      end
    end else begin
      chk("owner_lock", 64'(i), 64'(frame_owner));
    end
    frame_cnt++;
    e.cmd   = b;
    e.own   = 2'(i);
    e.done  = (frame_cnt == 8);
    e.abort = 1'b0;
    exp_q.push_back(e);
    if (frame_cnt == 8) in_frame = 1'b0;
  endtask

  // Requester models: hold valid while bytes are queued; with gaps enabled
  // only the current frame owner drops valid at random.
  initial begin : driver
    logic [N-1:0] hs;
    bit           gap;
    req_valid = '0;
    req_byte  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & ready;
      if (in_frame && ((ready & ~(N'(1) << frame_owner)) != '0)) leak_cnt++;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        req_valid = '0;
      end else begin
        for (int i = 0; i < N; i++) if (hs[i]) accept(i);
        for (int i = 0; i < N; i++) begin
          gap = gap_en && in_frame && (frame_owner == i) && ($urandom_range(3) == 0);
          if (!req_valid[i] && src_q[i].size() != 0 && !gap && raise_cyc < 0) raise_cyc = cyc;
          req_valid[i]      = (src_q[i].size() != 0) && !gap;
          req_byte[i*8 +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    obs_word = '0;
    forever begin
      @(negedge clk);
      if (des_valid) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("des_out{cmd,own,done,abort}", 64'({des_cmd, owner, done, abort}), 64'(e));
        end
        obs_word = {obs_word[55:0], des_cmd};
        if (first_des_cyc < 0) first_des_cyc = cyc;
        last_des_cyc = cyc;
      end else if (done || abort) begin
        chk("stray_pulse", 64'({done, abort}), 64'd0);
      end
      if (abort) begin
        abort_seen = 1'b1;
        abort_cyc  = cyc;
      end
    end
  end

  initial begin : monitor_nto
    n4 = 0; dn4_cnt = 0; ab4_cnt = 0; w4 = '0;
    forever begin
      @(negedge clk);
      if (dv4) begin
        n4++;
        w4 = {w4[55:0], c4};
      end
      if (dn4) dn4_cnt++;
      if (ab4) ab4_cnt++;
    end
  end

  task automatic wait_drain(input int max_cyc, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || (src_q[0].size() + src_q[1].size() + src_q[2].size()) != 0
            || busy) && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 64'({busy, 16'(exp_q.size() + src_q[0].size() + src_q[1].size() + src_q[2].size())}), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    in_frame  = 1'b0;
    frame_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int n;
    exp_t e;
    rst_n = 1'b0;
    v4 = '0; b4 = '0;
    leak_cnt = 0; raise_cyc = -1; first_des_cyc = -1; last_des_cyc = 0;
    abort_cyc = 0; last_hs_cyc = 0; frame_owner = 0; frame_cnt = 0;
    for (int i = 0; i < N; i++) wait_frames[i] = 0;
    #1;
    chk("reset_outputs", 64'({des_valid, des_cmd, owner, busy, done, abort, ready}), 64'd0);
    chk("reset_outputs_nto", 64'({dv4, c4, own4, busy4, dn4, ab4, r4}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: single frame from req0, order, latency, sustained rate
    @(negedge clk); #1;
    raise_cyc = -1; first_des_cyc = -1; obs_word = '0;
    for (int k = 1; k <= 8; k++) src_q[0].push_back(8'(k));
    wait_drain(100, "t1_drain");
    chk("t1_word", obs_word, 64'h0102030405060708);
    chk("t1_latency", 64'(first_des_cyc - raise_cyc), 64'd2);
    chk("t1_sustained", 64'(last_des_cyc - first_des_cyc), 64'd7);
    chk("t1_owner_hold", 64'(owner), 64'd0);

    // 2: contention from reset, then contention again
    pulse_reset();
    @(negedge clk); #1;
    frame_log.delete(); leak_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      src_q[0].push_back(8'(8'h10 + k));
      src_q[1].push_back(8'(8'h20 + k));
    end
    wait_drain(100, "t2_drain_a");
    for (int k = 0; k < 8; k++) begin
      src_q[0].push_back(8'(8'h30 + k));
      src_q[1].push_back(8'(8'h40 + k));
    end
    wait_drain(100, "t2_drain_b");
    chk("t2_frames", 64'(frame_log.size()), 64'd4);
    if (frame_log.size() == 4) begin
      chk("t2_order", 64'({4'(frame_log[0]), 4'(frame_log[1]), 4'(frame_log[2]), 4'(frame_log[3])}),
          64'h0101);
    end
    chk("t2_no_leak", 64'(leak_cnt), 64'd0);

    // 3: req1 stalls after 3 bytes -> 5 zero pads with abort
    for (int k = 1; k <= 3; k++) src_q[1].push_back(8'(8'hA0 + k));
    n = 0;
    while (!(in_frame && frame_cnt == 3) && n < 50) begin @(negedge clk); #1; n++; end
    chk("t3_three_bytes", 64'(frame_cnt), 64'd3);
    for (int p = 0; p < 5; p++) begin
      e.cmd = 8'h00; e.own = 2'd1; e.done = 1'b0; e.abort = (p == 4);
      exp_q.push_back(e);
    end
    in_frame = 1'b0; frame_cnt = 0; abort_seen = 1'b0;
    n = 0;
    while (!abort_seen && n < 400) begin @(negedge clk); #1; n++; end
    chk("t3_abort_seen", 64'(abort_seen), 64'd1);
    chk("t3_abort_time", 64'(abort_cyc - last_hs_cyc), 64'(TIMEOUT + 1 + 5));
    chk("t3_pads_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk); #1;
    chk("t3_busy_low", 64'(busy), 64'd0);

    // 4: timeout disabled, long mid-frame stall
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) begin
        repeat (1000) @(negedge clk);
        chk("t4_no_pad", 64'(n4), 64'd4);
        chk("t4_still_locked", 64'({busy4, ab4_cnt[7:0]}), 64'h100);
      end
      @(posedge clk); #1;
      v4 = 2'b01;
      b4[7:0] = 8'(k);
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        n++;
        if (r4[0]) break;
      end
      @(posedge clk); #1;
      v4 = 2'b00;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("t4_count", 64'(n4), 64'd8);
    chk("t4_word", w4, 64'h0102030405060708);
    chk("t4_done_abort", 64'({dn4_cnt[7:0], ab4_cnt[7:0]}), 64'h0100);

    // 5: reset mid-frame, then clean restart
    @(negedge clk); #1;
    frame_log.delete();
    for (int k = 1; k <= 8; k++) src_q[1].push_back(8'(8'h50 + k));
    n = 0;
    while (!(in_frame && frame_cnt == 4) && n < 50) begin @(negedge clk); #1; n++; end
    chk("t5_four_bytes", 64'(frame_cnt), 64'd4);
    chk("t5_owner_before", 64'(owner), 64'd1);
    #1;
    rst_n = 1'b0;
    src_q[1].delete(); exp_q.delete(); frame_log.delete();
    in_frame = 1'b0; frame_cnt = 0;
    #1;
    chk("t5_async_clear", 64'({des_valid, des_cmd, owner, busy, done, abort, ready}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      src_q[0].push_back(8'(8'h60 + k));
      src_q[1].push_back(8'(8'h70 + k));
    end
    wait_drain(100, "t5_drain");
    chk("t5_frames", 64'(frame_log.size()), 64'd2);
    if (frame_log.size() == 2) chk("t5_order", 64'({4'(frame_log[0]), 4'(frame_log[1])}), 64'h01);

    // 6: random owner gaps, three requesters, 501 frames
    gap_en = 1'b1; leak_cnt = 0; frame_log.delete();
    for (int i = 0; i < N; i++) wait_frames[i] = 0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 167 * 8; k++) src_q[i].push_back(8'($urandom_range(255)));
    wait_drain(30000, "t6_drain");
    gap_en = 1'b0;
    chk("t6_frames", 64'(frame_log.size()), 64'd501);
    chk("t6_no_leak", 64'(leak_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
